// File: rtl/siso_ctrl.sv
// Serial-in/serial-out controller: serializes a word LSB first into an external
// shift chain and recaptures it from the chain output after LATENCY clocks.
module siso_ctrl #(
  parameter int DATA_WIDTH = 4,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  abort,
  output logic                  ser_out,
  input  logic                  ser_in,
  output logic                  sr_en,
  output logic                  sr_clr,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy
);

  localparam int TOTAL = DATA_WIDTH + LATENCY;
  localparam int CNT_W = $clog2(TOTAL + 1);

  localparam logic [CNT_W-1:0] LAST_K    = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] FIRST_CAP = CNT_W'(LATENCY);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] word;
  logic [DATA_WIDTH-1:0] cap;

  // cnt holds the cycle index k across SHIFT and DRAIN; word shifts right so
  // word[0] is always the next bit to send.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      word        <= '0;
      cap         <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      sr_clr      <= 1'b0;
      sr_en       <= 1'b0;
      ser_out     <= 1'b0;
      busy        <= 1'b0;
      start_ready <= 1'b1;
    end else begin
      sr_clr   <= 1'b0;
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          sr_en   <= 1'b0;
          ser_out <= 1'b0;
          cnt     <= '0;
          if (start_valid) begin
            word        <= tx_data;
            state       <= CLEAR;
            sr_clr      <= 1'b1;
            busy        <= 1'b1;
            start_ready <= 1'b0;
          end
        end
        CLEAR: begin
          if (abort) begin
            state       <= IDLE;
            sr_clr      <= 1'b1;
            sr_en       <= 1'b0;
            ser_out     <= 1'b0;
            busy        <= 1'b0;
            start_ready <= 1'b1;
            cnt         <= '0;
          end else begin
            state   <= SHIFT;
            cnt     <= '0;
            sr_en   <= 1'b1;
            ser_out <= word[0];
            word    <= word >> 1;
          end
        end
        SHIFT, DRAIN: begin
          if (abort) begin
            // Abandon: clear the chain, leave rx_data untouched
            state       <= IDLE;
            sr_clr      <= 1'b1;
            sr_en       <= 1'b0;
            ser_out     <= 1'b0;
            busy        <= 1'b0;
            start_ready <= 1'b1;
            cnt         <= '0;
          end else begin
            if (cnt >= FIRST_CAP) begin
              cap <= {ser_in, cap[DATA_WIDTH-1:1]};
            end
            if (cnt == LAST_K) begin
              state    <= DONE;
              rx_valid <= 1'b1;
              rx_data  <= {ser_in, cap[DATA_WIDTH-1:1]};
              sr_en    <= 1'b0;
              ser_out  <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
              if (cnt < LAST_BIT) begin
                state   <= SHIFT;
                ser_out <= word[0];
                word    <= word >> 1;
              end else begin
                state   <= DRAIN;
                ser_out <= 1'b0;
              end
            end
          end
        end
        DONE: begin
          state       <= IDLE;
          busy        <= 1'b0;
          start_ready <= 1'b1;
          sr_en       <= 1'b0;
          ser_out     <= 1'b0;
          cnt         <= '0;
        end
        default: begin
          state       <= IDLE;
          busy        <= 1'b0;
          start_ready <= 1'b1;
          sr_en       <= 1'b0;
          ser_out     <= 1'b0;
          cnt         <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_siso_ctrl.sv
// Bench for siso_ctrl: two instances (4-bit/latency 4 and 8-bit/latency 1), each
// looped back through a modelled shift chain, checked against a cycle-index reference.
module tb_siso_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_valid;
  logic       abort;
  logic       sel;
  logic [7:0] tx_data;

  int checks = 0;
  int errors = 0;
  logic [7:0] last_rx [2];

  always #5 clk = ~clk;

  logic       sv4, ab4, ready4, so4, si4, en4, clr4, rv4, busy4;
  logic [3:0] rx4;
  logic       sv8, ab8, ready8, so8, si8, en8, clr8, rv8, busy8;
  logic [7:0] rx8;
  logic [3:0] chain4;
  logic       chain8;

  assign sv4 = start_valid & ~sel;
  assign ab4 = abort & ~sel;
  assign sv8 = start_valid & sel;
  assign ab8 = abort & sel;

  siso_ctrl #(.DATA_WIDTH(4), .LATENCY(4)) u4 (
    .clk(clk), .rst(rst), .start_valid(sv4), .start_ready(ready4),
    .tx_data(tx_data[3:0]), .abort(ab4), .ser_out(so4), .ser_in(si4),
    .sr_en(en4), .sr_clr(clr4), .rx_data(rx4), .rx_valid(rv4), .busy(busy4)
  );

  siso_ctrl #(.DATA_WIDTH(8), .LATENCY(1)) u8 (
    .clk(clk), .rst(rst), .start_valid(sv8), .start_ready(ready8),
    .tx_data(tx_data), .abort(ab8), .ser_out(so8), .ser_in(si8),
    .sr_en(en8), .sr_clr(clr8), .rx_data(rx8), .rx_valid(rv8), .busy(busy8)
  );

  // Shift chains: LATENCY flops from ser_out to ser_in, cleared by sr_clr
  always @(posedge clk) begin
    if (clr4) chain4 <= '0;
    else      chain4 <= {chain4[2:0], so4};
    if (clr8) chain8 <= 1'b0;
    else      chain8 <= so8;
  end
  assign si4 = en4 ? chain4[3] : 1'b0;
  assign si8 = en8 ? chain8 : 1'b0;

  logic       o_ready, o_so, o_en, o_clr, o_rv, o_busy;
  logic [7:0] o_rx;
  assign o_ready = sel ? ready8 : ready4;
  assign o_so    = sel ? so8 : so4;
  assign o_en    = sel ? en8 : en4;
  assign o_clr   = sel ? clr8 : clr4;
  assign o_rv    = sel ? rv8 : rv4;
  assign o_busy  = sel ? busy8 : busy4;
  assign o_rx    = sel ? rx8 : {4'b0, rx4};

  // Reference: after the handshake edge, cycle n=0 is CLEAR, n=1..W sends bit
  // n-1, n=W+1..W+L drains, n=W+L+1 pulses rx_valid with the sent word.
  task automatic run_xfer(input logic [7:0] d, input int abort_at);
    int dw, lat, tot;
    logic [7:0] dm;
    logic [5:0] exp_v, obs_v;
    logic b_e, clr_e, en_e, so_e, rv_e;
    dw  = sel ? 8 : 4;
    lat = sel ? 1 : 4;
    tot = dw + lat;
    dm  = sel ? d : {4'b0, d[3:0]};
    @(negedge clk);
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL xfer_ready_idle: got %b expected 1", o_ready);
    end
    start_valid = 1'b1;
    tx_data     = dm;
    abort       = 1'($urandom);
    for (int n = 0; n <= tot + 2; n++) begin
      @(negedge clk);
      b_e   = (n <= tot + 1);
      clr_e = (n == 0);
      en_e  = (n >= 1) && (n <= tot);
      so_e  = ((n >= 1) && (n <= dw)) ? dm[n-1] : 1'b0;
      rv_e  = (n == tot + 1);
      if (rv_e) last_rx[sel] = dm;
      exp_v = {b_e, ~b_e, clr_e, en_e, so_e, rv_e};
      obs_v = {o_busy, o_ready, o_clr, o_en, o_so, o_rv};
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL xfer_ctrl n=%0d w=%0d: got %b expected %b (busy,ready,clr,en,ser,rv)", n, dw, obs_v, exp_v);
      end
      checks++;
      if (o_rx !== last_rx[sel]) begin
        errors++;
        $display("FAIL xfer_rx_data n=%0d: got %h expected %h", n, o_rx, last_rx[sel]);
      end
      if (n == abort_at) begin
        abort       = 1'b1;
        start_valid = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({o_busy, o_ready, o_clr, o_en, o_so, o_rv} !== 6'b011000) begin
          errors++;
          $display("FAIL abort_ctrl n=%0d: got %b expected 011000", n,
                   {o_busy, o_ready, o_clr, o_en, o_so, o_rv});
        end
        checks++;
        if (o_rx !== last_rx[sel]) begin
          errors++;
          $display("FAIL abort_rx_data: got %h expected %h", o_rx, last_rx[sel]);
        end
        return;
      end
      start_valid = (n < tot) ? 1'($urandom) : 1'b0;
      tx_data     = 8'($urandom);
      abort       = (n == tot + 1) ? 1'($urandom) : 1'b0;
    end
    abort = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy4, ready4, clr4, en4, so4, rv4, rx4} !== {6'b010000, 4'h0}) begin
      errors++;
      $display("FAIL reset_u4: got %b expected 0100000000", {busy4, ready4, clr4, en4, so4, rv4, rx4});
    end
    checks++;
    if ({busy8, ready8, clr8, en8, so8, rv8, rx8} !== {6'b010000, 8'h00}) begin
      errors++;
      $display("FAIL reset_u8: got %b expected 01000000000000", {busy8, ready8, clr8, en8, so8, rv8, rx8});
    end
    rst = 1'b1;
  endtask

  task automatic test_idle();
    sel = 1'b0;
    start_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({busy4, clr4, en4, so4} !== 4'b0000) begin
        errors++;
        $display("FAIL idle_stable cycle %0d: got %b expected 0000", i, {busy4, clr4, en4, so4});
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc, hs, np;
    logic hs_next;
    int stamp [2];
    logic [7:0] data [2];
    sel = 1'b0;
    hs = 0;
    np = 0;
    cyc = 0;
    @(negedge clk);
    start_valid = 1'b1;
    tx_data = 8'h0A;
    while (cyc < 40) begin
      hs_next = o_ready & start_valid;
      @(negedge clk);
      cyc++;
      if (hs_next) begin
        hs++;
        if (hs == 1) tx_data = 8'h05;
        if (hs == 2) start_valid = 1'b0;
      end
      if (o_rv) begin
        if (np < 2) begin
          stamp[np] = cyc;
          data[np]  = o_rx;
        end
        np++;
      end
    end
    start_valid = 1'b0;
    checks++;
    if (np != 2 || hs != 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d pulses %0d handshakes expected 2 and 2", np, hs);
    end else begin
      checks++;
      if (stamp[0] != 10 || stamp[1] - stamp[0] != 11) begin
        errors++;
        $display("FAIL b2b_timing: got %0d,%0d expected 10,21", stamp[0], stamp[1]);
      end
      checks++;
      if (data[0] !== 8'h0A || data[1] !== 8'h05) begin
        errors++;
        $display("FAIL b2b_data: got %h,%h expected 0a,05", data[0], data[1]);
      end
    end
    last_rx[0] = 8'h05;
  endtask

  task automatic test_abort();
    sel = 1'b0;
    run_xfer(8'h06, -1);
    run_xfer(8'h0F, 2);
    repeat (12) begin
      @(negedge clk);
      checks++;
      if (rv4 !== 1'b0 || {4'b0, rx4} !== last_rx[0]) begin
        errors++;
        $display("FAIL abort_after: got rv=%b rx=%h expected rv=0 rx=%h", rv4, rx4, last_rx[0]);
      end
    end
  endtask

  task automatic test_async_reset();
    int np;
    logic [7:0] got;
    sel = 1'b0;
    run_xfer(8'h0C, -1);
    @(negedge clk);
    start_valid = 1'b1;
    tx_data = 8'h03;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({busy4, ready4, clr4, en4, so4, rv4, rx4} !== {6'b010000, 4'h0}) begin
      errors++;
      $display("FAIL async_reset: got %b expected 0100000000", {busy4, ready4, clr4, en4, so4, rv4, rx4});
    end
    last_rx[0] = 8'h00;
    last_rx[1] = 8'h00;
    @(negedge clk);
    rst = 1'b1;
    start_valid = 1'b1;
    tx_data = 8'h0B;
    @(negedge clk);
    start_valid = 1'b0;
    checks++;
    if ({busy4, clr4} !== 2'b11) begin
      errors++;
      $display("FAIL first_handshake: got busy,clr=%b expected 11", {busy4, clr4});
    end
    np = 0;
    got = 8'h00;
    repeat (14) begin
      @(negedge clk);
      if (rv4) begin
        np++;
        got = {4'b0, rx4};
      end
    end
    checks++;
    if (np != 1 || got !== 8'h0B) begin
      errors++;
      $display("FAIL post_reset_xfer: got %0d pulses data %h expected 1 pulse data 0b", np, got);
    end
    last_rx[0] = 8'h0B;
  endtask

  task automatic test_random();
    int dw, lat, ab;
    for (int i = 0; i < 30; i++) begin
      sel = 1'($urandom);
      dw  = sel ? 8 : 4;
      lat = sel ? 1 : 4;
      ab  = ($urandom_range(0, 9) < 3) ? int'($urandom_range(0, dw + lat)) : -1;
      run_xfer(8'($urandom), ab);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    start_valid = 1'b0;
    abort = 1'b0;
    sel = 1'b0;
    tx_data = 8'h00;
    last_rx[0] = 8'h00;
    last_rx[1] = 8'h00;
    test_reset();
    test_idle();
    sel = 1'b0;
    run_xfer(8'h09, -1);
    sel = 1'b1;
    run_xfer(8'hC3, -1);
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/siso_ctrl.md
SISO_CTRL -- requirements
Module: siso_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 4, giving the word width in bits (>=2).
REQ-002 The block SHALL have parameter LATENCY, default 4, giving the clocks from ser_out to ser_in through the attached shift chain (>=1).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port start_valid, input, 1 bit: request to send tx_data.
REQ-006 The block SHALL have port start_ready, output, 1 bit: controller accepts a request.
REQ-007 The block SHALL have port tx_data, input, DATA_WIDTH bits: word to serialize, LSB first.
REQ-008 The block SHALL have port abort, input, 1 bit: cancels the transfer in progress.
REQ-009 The block SHALL have port ser_out, output, 1 bit: serial data driven into the shift chain data input.
REQ-010 The block SHALL have port ser_in, input, 1 bit: serial data returned from the shift chain output.
REQ-011 The block SHALL have port sr_en, output, 1 bit: output enable for the shift chain.
REQ-012 The block SHALL have port sr_clr, output, 1 bit: one-cycle active-high clear pulse for the shift chain.
REQ-013 The block SHALL have port rx_data, output, DATA_WIDTH bits: word captured from ser_in.
REQ-014 The block SHALL have port rx_valid, output, 1 bit: one-cycle pulse, rx_data is new.
REQ-015 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, CLEAR, SHIFT, DRAIN, DONE, all state and outputs registered.
REQ-017 start_ready SHALL equal 1 only in IDLE; a handshake occurs on a rising edge with start_valid=1 and start_ready=1.
REQ-018 On handshake the block SHALL latch tx_data into an internal word and go IDLE->CLEAR.
REQ-019 CLEAR SHALL last exactly 1 cycle with sr_clr=1, sr_en=0, ser_out=0, then go to SHIFT with the bit counter at 0.
REQ-020 SHIFT SHALL last DATA_WIDTH cycles; in cycle k (0..DATA_WIDTH-1) ser_out=word[k] and sr_en=1.
REQ-021 DRAIN SHALL follow SHIFT and last LATENCY cycles with ser_out=0 and sr_en=1.
REQ-022 Capture: counting cycles k from the first SHIFT cycle, ser_in SHALL be sampled at the end of cycle k into rx_data[k-LATENCY] for LATENCY <= k < LATENCY+DATA_WIDTH.
REQ-023 Cycle k runs through SHIFT and DRAIN, DATA_WIDTH+LATENCY cycles in total; capture uses a counter of width clog2(DATA_WIDTH+LATENCY+1) and never wraps mid-transfer.
REQ-024 rx_data SHALL hold its last value outside capture and update only when rx_valid pulses.
REQ-025 DONE SHALL last 1 cycle with rx_valid=1 and sr_en=0, then go to IDLE.
REQ-026 Transfer latency from handshake edge to the rx_valid pulse SHALL be DATA_WIDTH+LATENCY+2 clocks.
REQ-027 start_valid SHALL be ignored while busy=1; a request held through DONE SHALL be accepted on the first IDLE cycle.
REQ-028 abort=1 in CLEAR, SHIFT or DRAIN SHALL send the FSM to IDLE on the next edge; sr_clr SHALL pulse in that transition cycle, rx_valid SHALL not pulse and rx_data SHALL be unchanged.
REQ-029 abort in IDLE or DONE SHALL have no effect; DONE SHALL still pulse rx_valid.
REQ-030 In IDLE, sr_en=0, sr_clr=0 and ser_out=0.

Reset
REQ-031 rst=0 SHALL immediately force state=IDLE, counter=0, word=0, rx_data=0, rx_valid=0, sr_clr=0, sr_en=0, ser_out=0, busy=0 and start_ready=1, independent of clk.
REQ-032 Reset asserted mid-transfer SHALL abandon the transfer with no rx_valid.
REQ-033 The first handshake SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-034 Loopback with a 4-bit chain: DATA_WIDTH=4, LATENCY=4, tx_data=4'b1001 -> ser_out sequence 1,0,0,1 then 0,0,0,0; rx_data=4'b1001; rx_valid 10 clocks after the handshake.
REQ-035 Back-to-back: start_valid held high with tx_data=4'hA and then 4'h5 -> two rx_valid pulses 11 clocks apart with rx_data 4'hA then 4'h5.
REQ-036 Abort: abort=1 in the second SHIFT cycle -> sr_clr pulses, busy=0 the next cycle, no rx_valid, rx_data retains its prior value.
REQ-037 Async reset: rst=0 between edges during DRAIN -> all outputs reach reset values before the next edge; no rx_valid afterwards.
REQ-038 LATENCY=1 with DATA_WIDTH=8 and tx_data=8'hC3 -> rx_data=8'hC3; rx_valid 11 clocks after the handshake.
REQ-039 Idle stability: start_valid=0 for 20 clocks -> busy=0, sr_en=0, sr_clr=0, ser_out=0 throughout.
